// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply, restoring divide.
// Optional macro MULDIV_EARLY_OUT_EN: MUL-class ops with a zero operand finish in one cycle.
module muldiv_unit #(
  parameter  int XLEN  = 32,
  localparam int CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic            kill,
  output logic            busy,
  output logic            stall,
  output logic            done,
  output logic [XLEN-1:0] result
);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_e;

  state_e            state_q;
  logic [1:0]        fn_q;
  logic              neg_q;
  logic [XLEN-1:0]   opb_q;
  logic [2*XLEN-1:0] acc_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [XLEN-1:0]   result_q;
  logic              done_q;

  logic              sgn_a, sgn_b, issue_neg;
  logic [XLEN-1:0]   abs_a, abs_b;
  logic              div_zero, div_ovf, mul_zero, special;
  logic [XLEN-1:0]   special_res;
  logic [XLEN:0]     mul_sum, div_shift, div_diff;
  logic [2*XLEN-1:0] acc_mul_d, acc_div_d, prod;
  logic [XLEN-1:0]   div_val, mul_res, div_res;

  always_comb begin
    // Signed operands: MULH (both), MULHSU (rs1 only), DIV/REM (both).
    sgn_a = rs1[XLEN-1] & ((funct3 == 3'b001) | (funct3 == 3'b010) | (funct3[2] & ~funct3[0]));
    sgn_b = rs2[XLEN-1] & ((funct3 == 3'b001) | (funct3[2] & ~funct3[0]));
    abs_a = sgn_a ? -rs1 : rs1;
    abs_b = sgn_b ? -rs2 : rs2;
    issue_neg = (funct3[2] & funct3[1]) ? sgn_a : (sgn_a ^ sgn_b);

    div_zero = funct3[2] & (rs2 == '0);
    div_ovf  = funct3[2] & ~funct3[0] & (rs1 == {1'b1, {(XLEN-1){1'b0}}}) & (&rs2);
`ifdef MULDIV_EARLY_OUT_EN
    mul_zero = ~funct3[2] & ((rs1 == '0) | (rs2 == '0));
`else
    mul_zero = 1'b0;
`endif
    special = div_zero | div_ovf | mul_zero;
    special_res = '0;
    if (div_zero)     special_res = funct3[1] ? rs1 : '1;
    else if (div_ovf) special_res = funct3[1] ? '0 : rs1;

    // Multiply step: acc = {partial product high, remaining multiplier bits}.
    mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opb_q} : '0);
    acc_mul_d = {mul_sum, acc_q[XLEN-1:1]};

    // Divide step: acc = {partial remainder, dividend bits shifting into quotient}.
    div_shift = acc_q[2*XLEN-1:XLEN-1];
    div_diff  = div_shift - {1'b0, opb_q};
    acc_div_d = {(div_diff[XLEN] ? div_shift[XLEN-1:0] : div_diff[XLEN-1:0]),
                 acc_q[XLEN-2:0], ~div_diff[XLEN]};

    prod    = neg_q ? -acc_mul_d : acc_mul_d;
    mul_res = (fn_q == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    div_val = fn_q[1] ? acc_div_d[2*XLEN-1:XLEN] : acc_div_d[XLEN-1:0];
    div_res = neg_q ? -div_val : div_val;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      fn_q     <= '0;
      neg_q    <= 1'b0;
      opb_q    <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start && !kill) begin
            fn_q  <= funct3[1:0];
            neg_q <= issue_neg;
            cnt_q <= CNT_W'(XLEN);
            if (special) begin
              result_q <= special_res;
              done_q   <= 1'b1;
              state_q  <= S_DONE;
            end else if (funct3[2]) begin
              opb_q   <= abs_b;
              acc_q   <= {{XLEN{1'b0}}, abs_a};
              state_q <= S_DIV;
            end else begin
              opb_q   <= abs_a;
              acc_q   <= {{XLEN{1'b0}}, abs_b};
              state_q <= S_MUL;
            end
          end
        end
        S_MUL, S_DIV: begin
          if (kill) begin
            state_q <= S_IDLE;
          end else begin
            acc_q <= (state_q == S_MUL) ? acc_mul_d : acc_div_d;
            cnt_q <= cnt_q - CNT_W'(1);
            // Final iteration: sign-correct and register the result on the way into DONE.
            if (cnt_q == CNT_W'(1)) begin
              result_q <= (state_q == S_MUL) ? mul_res : div_res;
              done_q   <= 1'b1;
              state_q  <= S_DONE;
            end
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Handshake: while stall=1 the pipeline holds start/funct3/rs1/rs2; done pulses one cycle with result.
  assign busy   = (state_q == S_MUL) | (state_q == S_DIV);
  assign stall  = busy | (start & (state_q == S_IDLE) & ~kill);
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed RV32M cases, kill/reset aborts, random ops vs a reference model.
module tb_muldiv_unit;
  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst, start, kill;
  logic [2:0]      funct3;
  logic [XLEN-1:0] rs1, rs2, result;
  logic            busy, stall, done;

  int n_checks = 0;
  int n_fail   = 0;
  logic [XLEN-1:0] exp_q[$];
  int              lat_q[$];
  logic [XLEN-1:0] last_res;

  always #5 clk = ~clk;

  muldiv_unit #(.XLEN(XLEN)) dut (
    .clk(clk), .rst(rst), .start(start), .funct3(funct3), .rs1(rs1), .rs2(rs2),
    .kill(kill), .busy(busy), .stall(stall), .done(done), .result(result)
  );

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [31:0] ref_res(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint          sa, sb;
    longint unsigned ua, ub;
    logic [63:0]     p;
    logic [31:0]     r;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'b0, a};
    ub = {32'b0, b};
    p  = '0;
    r  = '0;
    case (f)
      3'b000: begin p = ua * ub; r = p[31:0]; end
      3'b001: begin p = sa * sb; r = p[63:32]; end
      3'b010: begin p = sa * ub; r = p[63:32]; end
      3'b011: begin p = ua * ub; r = p[63:32]; end
      3'b100: begin
        if (b == 0) r = 32'hFFFF_FFFF;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = a;
        else begin p = sa / sb; r = p[31:0]; end
      end
      3'b101: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'b110: begin
        if (b == 0) r = a;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'h0;
        else begin p = sa % sb; r = p[31:0]; end
      end
      default: r = (b == 0) ? a : a % b;
    endcase
    return r;
  endfunction

  function automatic int ref_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    if (f[2] && (b == 0 || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) return 1;
`ifdef MULDIV_EARLY_OUT_EN
    if (!f[2] && (a == 0 || b == 0)) return 1;
`endif
    return XLEN + 1;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'h1;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return $urandom_range(0, 255);
      default: return $urandom;
    endcase
  endfunction

  // Consumer side of the scoreboard: waits for done, pops and compares.
  task automatic collect(input string tag);
    int cyc, bad_hold, l;
    bit got;
    logic [XLEN-1:0] e;
    cyc = 1; bad_hold = 0; got = 1'b0;
    while (!got && cyc <= 40) begin
      @(negedge clk);
      if (done === 1'b1) got = 1'b1;
      else begin
        if (busy !== 1'b1 || stall !== 1'b1) bad_hold++;
        @(posedge clk);
        cyc++;
      end
    end
    e = exp_q.pop_front();
    l = lat_q.pop_front();
    last_res = e;
    n_checks++;
    if (!got) begin
      n_fail++;
      $display("FAIL %s timeout: no done by cycle 40, required at cycle %0d", tag, l);
    end else begin
      n_checks++;
      if (result !== e) begin n_fail++; $display("FAIL %s result: got %h required %h", tag, result, e); end
      n_checks++;
      if (cyc != l) begin n_fail++; $display("FAIL %s latency: done at cycle %0d required %0d", tag, cyc, l); end
      n_checks++;
      if (stall !== 1'b0) begin n_fail++; $display("FAIL %s stall_at_done: got %b required 0", tag, stall); end
      n_checks++;
      if (bad_hold != 0) begin n_fail++; $display("FAIL %s hold: %0d cycles without busy&stall, required 0", tag, bad_hold); end
      @(posedge clk); #1;
      n_checks++;
      if (done !== 1'b0) begin n_fail++; $display("FAIL %s done_pulse: got %b after done cycle, required 0", tag, done); end
    end
  endtask

  task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] e);
    @(negedge clk);
    funct3 = f; rs1 = a; rs2 = b; start = 1'b1;
    exp_q.push_back(e);
    lat_q.push_back(ref_lat(f, a, b));
    #1;
    n_checks++;
    if (stall !== 1'b1) begin n_fail++; $display("FAIL %s stall_issue: got %b required 1", tag, stall); end
    @(posedge clk); #1;
    start = 1'b0;
    collect(tag);
  endtask

  task automatic test_reset;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b required 0", busy); end
    n_checks++;
    if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b required 0", done); end
    n_checks++;
    if (result !== '0) begin n_fail++; $display("FAIL reset_result: got %h required 0", result); end
    n_checks++;
    if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b required 0", stall); end
    rst = 1'b0;
  endtask

  task automatic test_mul_basic;
    run_op("mul_6x7", 3'b000, 32'd6, 32'd7, 32'd42);
    run_op("mul_neg", 3'b000, 32'hFFFF_FFF9, 32'd3, 32'hFFFF_FFEB);
  endtask

  task automatic test_mulh;
    run_op("mulh", 3'b001, 32'hFFFF_FFF9, 32'd3, 32'hFFFF_FFFF);
    run_op("mulhu", 3'b011, 32'hFFFF_FFF9, 32'd3, 32'h0000_0002);
    run_op("mulhsu", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
  endtask

  task automatic test_div;
    run_op("div_neg", 3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
    run_op("rem_neg", 3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
    run_op("divu", 3'b101, 32'd100, 32'd7, 32'd14);
    run_op("remu", 3'b111, 32'd100, 32'd7, 32'd2);
  endtask

  task automatic test_special;
    run_op("divu_by0", 3'b101, 32'd5, 32'd0, 32'hFFFF_FFFF);
    run_op("rem_by0", 3'b110, 32'd5, 32'd0, 32'd5);
    run_op("div_ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    run_op("rem_ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0);
    run_op("div_by0", 3'b100, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFFF);
  endtask

  task automatic test_kill;
    bit saw;
    logic [XLEN-1:0] prev;
    prev = last_res;
    saw  = 1'b0;
    @(negedge clk);
    funct3 = 3'b000; rs1 = 32'd123; rs2 = 32'd456; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 1; c < 10; c++) begin
      @(negedge clk);
      if (done === 1'b1) saw = 1'b1;
      @(posedge clk);
    end
    @(negedge clk);
    kill = 1'b1;
    if (done === 1'b1) saw = 1'b1;
    @(posedge clk); #1;
    kill = 1'b0;
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL kill_busy: got %b required 0", busy); end
    n_checks++;
    if (done !== 1'b0 || saw) begin n_fail++; $display("FAIL kill_done: got done %b seen %b required 0", done, saw); end
    n_checks++;
    if (result !== prev) begin n_fail++; $display("FAIL kill_result: got %h required %h", result, prev); end
    run_op("mul_after_kill", 3'b000, 32'd1000, 32'd1000, 32'd1000000);
  endtask

  task automatic test_kill_idle_done;
    bit saw;
    saw = 1'b0;
    @(negedge clk);
    funct3 = 3'b000; rs1 = 32'd3; rs2 = 32'd4; start = 1'b1; kill = 1'b1;
    #1;
    n_checks++;
    if (stall !== 1'b0) begin n_fail++; $display("FAIL kill_idle_stall: got %b required 0", stall); end
    @(posedge clk); #1;
    start = 1'b0; kill = 1'b0;
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL kill_idle_busy: got %b required 0", busy); end
    repeat (3) begin
      @(negedge clk);
      if (done === 1'b1) saw = 1'b1;
    end
    n_checks++;
    if (saw || result !== last_res) begin
      n_fail++; $display("FAIL kill_idle_noop: done seen %b result %h required 0 and %h", saw, result, last_res);
    end
    // Kill arriving in DONE must not suppress the completing result.
    @(negedge clk);
    funct3 = 3'b101; rs1 = 32'd77; rs2 = 32'd0; start = 1'b1;
    exp_q.push_back(32'hFFFF_FFFF);
    lat_q.push_back(1);
    @(posedge clk); #1;
    start = 1'b0; kill = 1'b1;
    collect("kill_in_done");
    kill = 1'b0;
  endtask

  task automatic test_back_to_back;
    @(negedge clk);
    funct3 = 3'b000; rs1 = 32'd11; rs2 = 32'd13; start = 1'b1;
    exp_q.push_back(32'd143);
    lat_q.push_back(XLEN + 1);
    @(posedge clk); #1;
    // start stays high with new operands: ignored while busy, accepted right after done.
    funct3 = 3'b101; rs1 = 32'd1000; rs2 = 32'd9;
    collect("ignore_first");
    exp_q.push_back(32'd111);
    lat_q.push_back(XLEN + 1);
    @(posedge clk); #1;
    start = 1'b0;
    collect("b2b_second");
  endtask

  task automatic test_early_out;
    run_op("mul_zero", 3'b000, 32'd0, 32'd9, 32'd0);
    run_op("mulh_zero", 3'b001, 32'hFFFF_FFFB, 32'd0, 32'd0);
  endtask

  task automatic test_random;
    logic [2:0]  f;
    logic [31:0] a, b;
    for (int i = 0; i < 40; i++) begin
      f = 3'($urandom_range(0, 7));
      a = pick();
      b = pick();
      run_op("random", f, a, b, ref_res(f, a, b));
    end
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    funct3 = 3'b100; rs1 = 32'd1000; rs2 = 32'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_busy: got %b required 0", busy); end
    n_checks++;
    if (done !== 1'b0) begin n_fail++; $display("FAIL rst_mid_done: got %b required 0", done); end
    n_checks++;
    if (result !== '0) begin n_fail++; $display("FAIL rst_mid_result: got %h required 0", result); end
    @(posedge clk); #1;
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL rst_mid_after: done %b busy %b required 0 0", done, busy);
    end
    last_res = '0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; kill = 1'b0; funct3 = '0; rs1 = '0; rs2 = '0; last_res = '0;
    test_reset;
    test_mul_basic;
    test_mulh;
    test_div;
    test_special;
    test_kill;
    test_kill_idle_done;
    test_back_to_back;
    test_early_out;
    test_random;
    test_reset_mid;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
